evaluate_taper: RTL and testbench

//  Downstream stage of the general evaluator. Blends its middlegame/endgame scores into one

---
 rtl/evaluate_taper.sv | 163 ++++++++++++++++
 tb/tb_evaluate_taper.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/evaluate_taper.sv
// Tapered evaluation: blends middlegame/endgame scores by a game phase derived from the board.
// Piece codes are {colour, kind}: kind 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king.
`ifndef PIECE_WIDTH
`define PIECE_WIDTH 4
`endif
`ifndef BOARD_WIDTH
`define BOARD_WIDTH (64 * `PIECE_WIDTH)
`endif

module evaluate_taper #(
    parameter int EVAL_WIDTH    = 16,
    parameter bit SIDE_RELATIVE = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         board_valid,
    input  logic [`BOARD_WIDTH-1:0]      board,
    input  logic                         white_to_move,
    input  logic                         clear_eval,
    input  logic signed [EVAL_WIDTH-1:0] eval_mg_in,
    input  logic signed [EVAL_WIDTH-1:0] eval_eg_in,
    input  logic                         eval_in_valid,
    output logic signed [EVAL_WIDTH-1:0] eval,
    output logic                         eval_valid,
    output logic [4:0]                   phase
);

    localparam int PW  = `PIECE_WIDTH;
    localparam int P_W = EVAL_WIDTH + 10;
    localparam logic signed [EVAL_WIDTH-1:0] EVAL_MIN = {1'b1, {(EVAL_WIDTH-1){1'b0}}};
    localparam logic signed [EVAL_WIDTH-1:0] EVAL_MAX = {1'b0, {(EVAL_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, WAIT, MUL, FIN, DONE} state_t;

    state_t state, next_state;

    logic [2:0]                  units [64];
    logic                        units_valid;
    logic                        phase_ready;
    logic [4:0]                  phase_q;
    logic [8:0]                  unit_sum;
    logic                        start;
    logic                        stm_white;
    logic signed [EVAL_WIDTH-1:0] mg_q, eg_q, eval_q, fin_value, r_trunc;
    logic signed [P_W-1:0]       p_q, p_next;
    logic [8:0]                  w;
    logic signed [9:0]           w_s, w_inv_s;
    logic                        unused_p_bits;

    function automatic logic [2:0] piece_units(input logic [PW-1:0] piece);
        case (piece)
            4'd2, 4'd3, 4'd10, 4'd11: piece_units = 3'd1;
            4'd4, 4'd12:              piece_units = 3'd2;
            4'd5, 4'd13:              piece_units = 3'd4;
            default:                  piece_units = 3'd0;
        endcase
    endfunction

    // w = (phase*256+12)/24, tabulated so no divider is built.
    function automatic logic [8:0] weight_of(input logic [4:0] ph);
        case (ph)
            5'd0:  weight_of = 9'd0;    5'd1:  weight_of = 9'd11;
            5'd2:  weight_of = 9'd21;   5'd3:  weight_of = 9'd32;
            5'd4:  weight_of = 9'd43;   5'd5:  weight_of = 9'd53;
            5'd6:  weight_of = 9'd64;   5'd7:  weight_of = 9'd75;
            5'd8:  weight_of = 9'd85;   5'd9:  weight_of = 9'd96;
            5'd10: weight_of = 9'd107;  5'd11: weight_of = 9'd117;
            5'd12: weight_of = 9'd128;  5'd13: weight_of = 9'd139;
            5'd14: weight_of = 9'd149;  5'd15: weight_of = 9'd160;
            5'd16: weight_of = 9'd171;  5'd17: weight_of = 9'd181;
            5'd18: weight_of = 9'd192;  5'd19: weight_of = 9'd203;
            5'd20: weight_of = 9'd213;  5'd21: weight_of = 9'd224;
            5'd22: weight_of = 9'd235;  5'd23: weight_of = 9'd245;
            default: weight_of = 9'd256;
        endcase
    endfunction

    // clear_eval suppresses start, so a board arriving with it is dropped.
    assign start = (state == IDLE) && board_valid && !clear_eval;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every combinational output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (board_valid) next_state = WAIT;
            WAIT: if (eval_in_valid && phase_ready) next_state = MUL;
            MUL:  next_state = FIN;
            FIN:  next_state = DONE;
            DONE: next_state = DONE;
            default: next_state = IDLE;
        endcase
        if (clear_eval) next_state = IDLE;
    end

    always_comb begin
        unit_sum = '0;
        for (int i = 0; i < 64; i++) unit_sum = unit_sum + 9'(units[i]);
    end

    // NOTE: the per-square unit array is reset too, so a flushed pipeline can never replay an old board.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) units[i] <= '0;
            units_valid <= 1'b0;
            phase_ready <= 1'b0;
            phase_q     <= '0;
        end else begin
            units_valid <= start;
            if (start)
                for (int i = 0; i < 64; i++) units[i] <= piece_units(board[i*PW +: PW]);
            if (units_valid)
                phase_q <= (unit_sum > 9'd24) ? 5'd24 : unit_sum[4:0];
            if (clear_eval || start) phase_ready <= 1'b0;
            else if (units_valid)    phase_ready <= 1'b1;
        end
    end

    always_comb begin
        w       = weight_of(phase_q);
        w_s     = signed'({1'b0, w});
        w_inv_s = 10'sd256 - w_s;
        p_next  = P_W'(mg_q) * P_W'(w_s) + P_W'(eg_q) * P_W'(w_inv_s);
    end

    // Floor shift by 8; the weighted average is bounded by max(|mg|,|eg|), so the top bits are sign copies.
    assign r_trunc       = signed'(p_q[EVAL_WIDTH+7:8]);
    assign unused_p_bits = ^{p_q[7:0], p_q[P_W-1:EVAL_WIDTH+8]};

    always_comb begin
        fin_value = r_trunc;
        if (SIDE_RELATIVE && !stm_white)
            fin_value = (r_trunc == EVAL_MIN) ? EVAL_MAX : -r_trunc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stm_white <= 1'b0;
            mg_q      <= '0;
            eg_q      <= '0;
            p_q       <= '0;
            eval_q    <= '0;
        end else begin
            if (start) stm_white <= white_to_move;
            if (state == WAIT) begin
                mg_q <= eval_mg_in;
                eg_q <= eval_eg_in;
            end
            if (state == MUL) p_q <= p_next;
            if (state == FIN) eval_q <= fin_value;
        end
    end

    assign eval       = eval_q;
    assign eval_valid = (state == DONE);
    assign phase      = phase_q;

endmodule

// File: tb/tb_evaluate_taper.sv
// Self-checking bench for evaluate_taper: two instances (white-relative and side-relative)
// share stimulus; a reference model pushes expected results into a scoreboard queue.
module tb_evaluate_taper;

    localparam int W = 16;

    typedef struct {
        logic signed [W-1:0] ea;
        logic signed [W-1:0] er;
        logic [4:0]          ph;
        int                  lat;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                board_valid;
    logic [255:0]        board;
    logic                white_to_move;
    logic                clear_eval;
    logic signed [W-1:0] eval_mg_in, eval_eg_in;
    logic                eval_in_valid;
    logic signed [W-1:0] eval_a, eval_r;
    logic                valid_a, valid_r;
    logic [4:0]          phase_a, phase_r;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    evaluate_taper #(.EVAL_WIDTH(W), .SIDE_RELATIVE(1'b0)) u_abs (
        .clk(clk), .reset(reset), .board_valid(board_valid), .board(board),
        .white_to_move(white_to_move), .clear_eval(clear_eval),
        .eval_mg_in(eval_mg_in), .eval_eg_in(eval_eg_in), .eval_in_valid(eval_in_valid),
        .eval(eval_a), .eval_valid(valid_a), .phase(phase_a)
    );

    evaluate_taper #(.EVAL_WIDTH(W), .SIDE_RELATIVE(1'b1)) u_rel (
        .clk(clk), .reset(reset), .board_valid(board_valid), .board(board),
        .white_to_move(white_to_move), .clear_eval(clear_eval),
        .eval_mg_in(eval_mg_in), .eval_eg_in(eval_eg_in), .eval_in_valid(eval_in_valid),
        .eval(eval_r), .eval_valid(valid_r), .phase(phase_r)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] put(input logic [255:0] b, input int sq,
                                         input logic [3:0] p);
        logic [255:0] r;
        r = b;
        r[sq*4 +: 4] = p;
        return r;
    endfunction

    function automatic int model_phase(input logic [255:0] b);
        int s;
        logic [3:0] p;
        s = 0;
        for (int i = 0; i < 64; i++) begin
            p = b[i*4 +: 4];
            case (p[2:0])
                3'd2, 3'd3: s += 1;
                3'd4:       s += 2;
                3'd5:       s += 4;
                default:    s += 0;
            endcase
        end
        return (s > 24) ? 24 : s;
    endfunction

    // Reference model: push the expected outputs of both instances.
    task automatic push_expected(input logic [255:0] b, input logic wtm,
                                 input int mg, input int eg, input int k);
        exp_t  e;
        int    ph, w;
        longint p, r;
        ph = model_phase(b);
        w  = (ph * 256 + 12) / 24;
        p  = longint'(mg) * w + longint'(eg) * (256 - w);
        r  = p >>> 8;
        e.ph  = 5'(ph);
        e.ea  = W'(r);
        e.er  = wtm ? W'(r) : ((r == -32768) ? 16'sd32767 : W'(-r));
        e.lat = ((k + 1 > 2) ? k + 1 : 2) + 2;
        sb.push_back(e);
    endtask

    // Start a board, raise eval_in_valid k edges after board capture, wait for the result.
    task automatic run_case(input string tag, input logic [255:0] b, input logic wtm,
                            input int mg, input int eg, input int k);
        int   n;
        exp_t e;
        push_expected(b, wtm, mg, eg, k);
        @(negedge clk);
        board = b; white_to_move = wtm; board_valid = 1'b1;
        eval_mg_in = W'(mg); eval_eg_in = W'(eg);
        if (k == 0) eval_in_valid = 1'b1;
        @(negedge clk);
        board_valid = 1'b0;
        n = 0;
        while (!valid_a && n < 20) begin
            if (n == k && k > 0) eval_in_valid = 1'b1;
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, n, e.lat);
        check({tag, "_eval_abs"}, eval_a, e.ea);
        check({tag, "_eval_rel"}, eval_r, e.er);
        check({tag, "_phase"}, phase_a, e.ph);
        check({tag, "_valid_rel"}, valid_r, 1);
    endtask

    // Acknowledge: eval_valid drops next cycle, eval holds.
    task automatic acknowledge(input string tag);
        logic signed [W-1:0] held;
        held = eval_a;
        clear_eval = 1'b1;
        eval_in_valid = 1'b0;
        @(negedge clk);
        clear_eval = 1'b0;
        check({tag, "_ack_valid"}, valid_a, 0);
        check({tag, "_ack_hold"}, eval_a, held);
    endtask

    logic [255:0] start_pos, kp_only, rq_each, queens9, tmp;
    logic [3:0]   back_rank [8];

    initial begin
        back_rank = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
        start_pos = '0;
        for (int i = 0; i < 8; i++) begin
            start_pos = put(start_pos, i, back_rank[i]);
            start_pos = put(start_pos, 8 + i, 4'd1);
            start_pos = put(start_pos, 48 + i, 4'd9);
            start_pos = put(start_pos, 56 + i, back_rank[i] | 4'd8);
        end
        kp_only = '0;
        kp_only = put(kp_only, 4, 4'd6);
        kp_only = put(kp_only, 60, 4'd14);
        for (int i = 0; i < 8; i++) begin
            kp_only = put(kp_only, 8 + i, 4'd1);
            kp_only = put(kp_only, 48 + i, 4'd9);
        end
        rq_each = '0;
        rq_each = put(rq_each, 0, 4'd4);
        rq_each = put(rq_each, 3, 4'd5);
        rq_each = put(rq_each, 4, 4'd6);
        rq_each = put(rq_each, 56, 4'd12);
        rq_each = put(rq_each, 59, 4'd13);
        rq_each = put(rq_each, 60, 4'd14);
        queens9 = '0;
        queens9 = put(queens9, 4, 4'd6);
        queens9 = put(queens9, 60, 4'd14);
        queens9 = put(queens9, 56, 4'd12);
        queens9 = put(queens9, 63, 4'd12);
        for (int i = 0; i < 9; i++) queens9 = put(queens9, 16 + i, 4'd5);

        reset = 1'b1; board_valid = 1'b0; board = '0; white_to_move = 1'b1;
        clear_eval = 1'b0; eval_mg_in = '0; eval_eg_in = '0; eval_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", valid_a, 0);
        check("reset_eval", eval_a, 0);
        check("reset_phase", phase_r, 0);
        reset = 1'b0;

        run_case("start_pos", start_pos, 1'b1, 100, -50, 0);
        acknowledge("start_pos");
        run_case("kp_only", kp_only, 1'b1, 300, 40, 3);
        acknowledge("kp_only");
        run_case("rq_200", rq_each, 1'b1, 200, 0, 0);
        acknowledge("rq_200");
        run_case("rq_floor", rq_each, 1'b1, -3, 0, 1);
        acknowledge("rq_floor");
        run_case("rq_black", rq_each, 1'b0, -1000, 333, 2);
        acknowledge("rq_black");
        run_case("black_75", start_pos, 1'b0, 75, 10, 0);
        acknowledge("black_75");
        run_case("black_min", start_pos, 1'b0, -32768, 5, 0);
        acknowledge("black_min");
        run_case("queens9", queens9, 1'b1, 1234, -999, 0);

        // board_valid while DONE must not disturb the held result or restart the phase pipeline.
        tmp = eval_a;
        @(negedge clk);
        board = kp_only; board_valid = 1'b1;
        @(negedge clk);
        board_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("done_ignore_valid", valid_a, 1);
        check("done_ignore_eval", eval_a, 16'(tmp));
        check("done_ignore_phase", phase_a, 24);
        acknowledge("queens9");

        // Abort in WAIT before upstream is valid; later upstream valid in IDLE is ignored.
        @(negedge clk);
        board = start_pos; board_valid = 1'b1;
        @(negedge clk);
        board_valid = 1'b0;
        @(negedge clk);
        clear_eval = 1'b1;
        @(negedge clk);
        clear_eval = 1'b0;
        eval_in_valid = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_wait_valid", valid_a, 0);
        eval_in_valid = 1'b0;

        // clear_eval beats a same-cycle board_valid.
        @(negedge clk);
        board = rq_each; board_valid = 1'b1; clear_eval = 1'b1; eval_in_valid = 1'b1;
        @(negedge clk);
        board_valid = 1'b0; clear_eval = 1'b0;
        repeat (6) @(negedge clk);
        check("clear_beats_board", valid_a, 0);
        eval_in_valid = 1'b0;

        run_case("after_abort", rq_each, 1'b1, 200, 0, 0);
        acknowledge("after_abort");

        // Reset mid-operation returns everything to the reset state.
        @(negedge clk);
        board = start_pos; board_valid = 1'b1; eval_in_valid = 1'b1;
        eval_mg_in = 16'sd500; eval_eg_in = 16'sd500;
        @(negedge clk);
        board_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; eval_in_valid = 1'b0;
        check("midreset_valid", valid_a, 0);
        check("midreset_eval", eval_a, 0);
        check("midreset_phase", phase_a, 0);
        repeat (6) @(negedge clk);
        check("midreset_stays_idle", valid_r, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
